// File: rtl/serv_uart_rx.sv
// 8N1 UART receiver for a SERV core's TX pad: deserialises frames into bytes and buffers them
// in a small FIFO presented as a valid/ready byte stream.
module serv_uart_rx #(
  parameter int unsigned CLK_DIV    = 139,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLK_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bitidx_q, bitidx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            sample;
  logic            push;
  logic            frame_err_d;
  logic            frame_err_q, overrun_q;

  logic [AddrW:0]  wptr_q, rptr_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            empty, full, pop, push_ok;

  assign rx_s   = sync_q[1];
  assign sample = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q - CntW'(1);
    bitidx_d    = bitidx_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = cnt_q;
        if (!rx_s) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (sample) begin
          if (!rx_s) begin
            state_d  = StData;
            cnt_d    = FullLoad;
            bitidx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (sample) begin
          shreg_d  = {rx_s, shreg_q[7:1]};
          cnt_d    = FullLoad;
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (sample) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = cnt_q;
        // A held-low line stays here so it reports only one framing error.
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], rx_i};
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign pop   = !empty && ready_i;
  // When full, a same-cycle pop frees the head slot that the write then reuses.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AddrW-1:0]] <= shreg_q;
        wptr_q                   <= wptr_q + (AddrW + 1)'(1);
      end
      if (pop) rptr_q <= rptr_q + (AddrW + 1)'(1);
      frame_err_q <= frame_err_d;
      overrun_q   <= push && full && !pop;
    end
  end

  assign data_o      = mem_q[rptr_q[AddrW-1:0]];
  assign valid_o     = !empty;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_serv_uart_rx.sv
// Scoreboard bench for serv_uart_rx at 16 clocks per bit with a 4-entry FIFO.
module tb_serv_uart_rx;

  localparam int unsigned Div = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  logic [7:0]  exp_q[$];

  serv_uart_rx #(
    .CLK_DIV   (Div),
    .FIFO_DEPTH(4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .rx_i       (rx),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Div) @(negedge clk);
    end
    rx = stop;
    repeat (Div) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (!valid) break;
    end
    check("drain_empty", {31'd0, valid}, 32'd0);
    ready = 1'b0;
  endtask

  // Pop side of the scoreboard plus pulse counters.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (valid && ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", {24'd0, data}, 32'hFFFF_FFFF);
        else check("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    #2;
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    // Clean byte: busy and valid timing relative to the start edge.
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        idle(2); #2;
        check("busy_before", {31'd0, busy}, 32'd0);
        idle(1); #2;
        check("busy_after", {31'd0, busy}, 32'd1);
        idle(151); #2;
        check("valid_early", {31'd0, valid}, 32'd0);
        idle(1); #2;
        check("valid_rise", {31'd0, valid}, 32'd1);
        check("head_a5", {24'd0, data}, 32'hA5);
      end
    join
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    #2;
    check("after_pop", {31'd0, valid}, 32'd0);
    @(negedge clk);

    // Glitch shorter than half a bit.
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, valid}, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    drain();

    // Framing error followed by a long break.
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    idle(40 * Div);
    rx = 1'b1;
    idle(20);
    check("fe_count", fe_cnt, 32'd1);
    check("fe_valid", {31'd0, valid}, 32'd0);
    check("fe_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    drain();

    // Overrun: fifth byte dropped.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    idle(4);
    check("ovr_count", ov_cnt, 32'd1);
    check("ovr_head", {24'd0, data}, 32'h01);

    // Full FIFO with a pop on the stop-sample cycle of 0x77.
    exp_q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1);
      begin
        idle(154);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
      end
    join
    idle(4);
    check("full_pop_ovr", ov_cnt, 32'd1);
    check("full_pop_head", {24'd0, data}, 32'h02);
    drain();

    // Reset late in data bit 3 of 0xF0, with a byte already buffered.
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(2);
    check("pre_rst_valid", {31'd0, valid}, 32'd1);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        idle(76);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        #2;
        check("mid_rst_valid", {31'd0, valid}, 32'd0);
        check("mid_rst_data", {24'd0, data}, 32'h00);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
        idle(1); #2;
        check("post_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("post_rst_ovr", {31'd0, overrun}, 32'd0);
      end
    join
    idle(40);
    check("rst_no_push", {31'd0, valid}, 32'd0);
    check("rst_fe_count", fe_cnt, 32'd1);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(2);
    check("final_head", {24'd0, data}, 32'h0F);
    drain();

    idle(4);
    check("sb_left", exp_q.size(), 32'd0);
    check("final_fe", fe_cnt, 32'd1);
    check("final_ovr", ov_cnt, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
